// File: rtl/wb_pkg.sv
// Shared types and the default rv32i SoC address map for the Wishbone slave decoder.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } wb_dec_state_e;

    typedef enum logic [1:0] {
        RESP_ACK = 2'd0,
        RESP_ERR = 2'd1,
        RESP_RTY = 2'd2
    } wb_resp_e;

    localparam logic [31:0] DMEM_BASE = 32'h1000_0000;
    localparam logic [31:0] DMEM_MASK = 32'hFFFF_0000;
    localparam logic [31:0] IMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] IMEM_MASK = 32'hFFFF_0000;
    localparam logic [31:0] GPIO_BASE = 32'h2000_0000;
    localparam logic [31:0] GPIO_MASK = 32'hFFFF_FF00;
    localparam logic [31:0] UART_BASE = 32'h2000_0100;
    localparam logic [31:0] UART_MASK = 32'hFFFF_FF00;
    localparam logic [31:0] SPI_BASE  = 32'h3000_0000;
    localparam logic [31:0] SPI_MASK  = 32'hFF00_0000;

    // Slot i sits at bits [32*i +: 32], so DMEM is slave 0.
    localparam logic [5*32-1:0] SOC_SLAVE_BASE = {SPI_BASE, UART_BASE, GPIO_BASE, IMEM_BASE, DMEM_BASE};
    localparam logic [5*32-1:0] SOC_SLAVE_MASK = {SPI_MASK, UART_MASK, GPIO_MASK, IMEM_MASK, DMEM_MASK};

    // A slave raising several termination flags at once is reported as the worst one.
    function automatic wb_resp_e resp_pick(input logic err, input logic rty);
        if (err)      return RESP_ERR;
        else if (rty) return RESP_RTY;
        else          return RESP_ACK;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// BUSY-phase watchdog: counts enabled cycles since the last clear and flags the LIMIT-th one.
module wb_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds completed cycles, so the LIMIT-th enabled cycle is count == LIMIT-1.
    assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/wb_slave_decoder.sv
// Single-master, N-slave Wishbone classic decoder with base/mask map and registered handshake.
// Optional BUSY watchdog is built in when WB_DEC_TIMEOUT_EN is defined.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for cyc&stb; latches request and decodes the slave
//   BUSY    | selected slave strobed; waits for ack/err/rty or master abort
//   RESP    | one-cycle ack/err/rty pulse to the master
module wb_slave_decoder
    import wb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 5,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              m_adr_i,
    input  logic [31:0]              m_dat_i,
    input  logic [3:0]               m_sel_i,
    input  logic                     m_we_i,
    input  logic                     m_cyc_i,
    input  logic                     m_stb_i,
    output logic [31:0]              m_dat_o,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic                     m_rty_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    output logic [3:0]               s_sel_o,
    output logic                     s_we_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    input  logic [NUM_SLAVES*32-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES-1:0]    s_err_i,
    input  logic [NUM_SLAVES-1:0]    s_rty_i
);

    wb_dec_state_e         state;
    logic [NUM_SLAVES-1:0] sel_q;
    logic [NUM_SLAVES-1:0] hit_oh;
    logic                  hit;
    logic                  sel_ack;
    logic                  sel_err;
    logic                  sel_rty;
    logic [31:0]           rd_dat;
    logic                  wd_expire;

    // Lowest-index match wins when regions overlap.
    always_comb begin
        hit_oh = '0;
        hit    = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((m_adr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])) begin
                hit_oh[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) rd_dat = rd_dat | s_dat_i[32*i +: 32];
        end
    end

    assign sel_ack = |(s_ack_i & sel_q);
    assign sel_err = |(s_err_i & sel_q);
    assign sel_rty = |(s_rty_i & sel_q);

    assign s_cyc_o = (state == ST_BUSY) ? sel_q : '0;
    assign s_stb_o = (state == ST_BUSY) ? sel_q : '0;

`ifdef WB_DEC_TIMEOUT_EN
    wb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != ST_BUSY),
        .enable  (state == ST_BUSY),
        .expire  (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            sel_q   <= '0;
            s_adr_o <= '0;
            s_dat_o <= '0;
            s_sel_o <= '0;
            s_we_o  <= 1'b0;
            m_dat_o <= '0;
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_rty_o <= 1'b0;
        end else begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_rty_o <= 1'b0;
            m_dat_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        s_adr_o <= m_adr_i;
                        s_dat_o <= m_dat_i;
                        s_sel_o <= m_sel_i;
                        s_we_o  <= m_we_i;
                        sel_q   <= hit_oh;
                        if (hit) begin
                            state <= ST_BUSY;
                        end else begin
                            m_err_o <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_BUSY: begin
                    // A master abort takes precedence over a same-cycle slave response.
                    if (!m_cyc_i) begin
                        sel_q <= '0;
                        state <= ST_IDLE;
                    end else if (sel_ack || sel_err || sel_rty) begin
                        sel_q <= '0;
                        state <= ST_RESP;
                        case (resp_pick(sel_err, sel_rty))
                            RESP_ERR: m_err_o <= 1'b1;
                            RESP_RTY: m_rty_o <= 1'b1;
                            default: begin
                                m_ack_o <= 1'b1;
                                m_dat_o <= s_we_o ? 32'h0 : rd_dat;
                            end
                        endcase
                    end else if (wd_expire) begin
                        sel_q   <= '0;
                        m_err_o <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Self-checking bench for wb_slave_decoder: directed vector table, randomized traffic, corner sequences.
module tb_wb_slave_decoder;

    localparam int NS = 3;
    localparam logic [31:0] BASES [NS] = '{32'h0000_0000, 32'h2000_0000, 32'h0000_0000};
    localparam logic [31:0] MASKS [NS] = '{32'hFFFF_F000, 32'hFFFF_FF00, 32'hF000_0000};

    logic          clk;
    logic          reset_n;
    logic [31:0]   m_adr_i, m_dat_i;
    logic [3:0]    m_sel_i;
    logic          m_we_i, m_cyc_i, m_stb_i;
    logic [31:0]   m_dat_o;
    logic          m_ack_o, m_err_o, m_rty_o;
    logic [31:0]   s_adr_o, s_dat_o;
    logic [3:0]    s_sel_o;
    logic          s_we_o;
    logic [NS-1:0] s_cyc_o, s_stb_o;
    logic [NS*32-1:0] s_dat_i;
    logic [NS-1:0] s_ack_i, s_err_i, s_rty_i;

    int n_pass = 0;
    int n_total = 0;

    wb_slave_decoder #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASE     ({32'h0000_0000, 32'h2000_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({32'hF000_0000, 32'hFFFF_FF00, 32'hFFFF_F000}),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_we_i  (m_we_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_rty_i (s_rty_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags / exp_rsp are {err, rty, ack}; exp_slave < 0 means unmapped.
    typedef struct {
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdata;
        logic [3:0]  sel;
        logic        we;
        int          wt;
        logic [2:0]  flags;
        int          exp_slave;
        logic [2:0]  exp_rsp;
        logic [31:0] exp_dat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [31:0] slave_word(input int i, input logic [31:0] base);
        return base ^ (32'h1111_1111 * 32'(i));
    endfunction

    function automatic int model_slave(input logic [31:0] adr);
        for (int i = 0; i < NS; i++)
            if ((adr & MASKS[i]) == BASES[i]) return i;
        return -1;
    endfunction

    function automatic vec_t model_vec(input logic [31:0] adr, input logic [31:0] wdat, input logic [31:0] rdata,
                                       input logic [3:0] sel, input logic we, input int wt, input logic [2:0] flags);
        vec_t v;
        v.adr = adr; v.wdat = wdat; v.rdata = rdata; v.sel = sel; v.we = we; v.wt = wt; v.flags = flags;
        v.exp_slave = model_slave(adr);
        if (v.exp_slave < 0 || flags[2]) v.exp_rsp = 3'b100;
        else if (flags[1])               v.exp_rsp = 3'b010;
        else                             v.exp_rsp = 3'b001;
        v.exp_dat = (v.exp_rsp == 3'b001 && !we) ? slave_word(v.exp_slave, rdata) : 32'h0;
        return v;
    endfunction

    function automatic vec_t mk(input logic [31:0] adr, input logic [31:0] wdat, input logic [31:0] rdata,
                                input logic [3:0] sel, input logic we, input int wt, input logic [2:0] flags,
                                input int es, input logic [2:0] er, input logic [31:0] ed);
        vec_t v;
        v.adr = adr; v.wdat = wdat; v.rdata = rdata; v.sel = sel; v.we = we; v.wt = wt; v.flags = flags;
        v.exp_slave = es; v.exp_rsp = er; v.exp_dat = ed;
        return v;
    endfunction

    function automatic logic [NS-1:0] onehot(input int s);
        logic [NS-1:0] r;
        r = '0;
        if (s >= 0) r[s] = 1'b1;
        return r;
    endfunction

    task automatic idle_inputs();
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit noise);
        logic [NS-1:0] oh;
        oh = onehot(v.exp_slave);
        @(negedge clk);
        m_adr_i = v.adr; m_dat_i = v.wdat; m_sel_i = v.sel; m_we_i = v.we;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        for (int i = 0; i < NS; i++) s_dat_i[32*i +: 32] = slave_word(i, v.rdata);
        s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
        @(negedge clk);
        m_adr_i = ~v.adr; m_dat_i = ~v.wdat; m_sel_i = ~v.sel; m_we_i = ~v.we;
        if (v.exp_slave < 0) begin
            chk({tag, " unmapped rsp"}, 32'({m_err_o, m_rty_o, m_ack_o}), 32'(v.exp_rsp));
            chk({tag, " unmapped stb"}, 32'(s_stb_o), 32'h0);
            idle_inputs();
            @(negedge clk);
            chk({tag, " unmapped rsp pulse"}, 32'({m_err_o, m_rty_o, m_ack_o}), 32'h0);
            chk({tag, " unmapped stb after"}, 32'(s_stb_o), 32'h0);
            return;
        end
        chk({tag, " s_adr"}, s_adr_o, v.adr);
        chk({tag, " s_dat"}, s_dat_o, v.wdat);
        chk({tag, " s_sel/we"}, 32'({s_sel_o, s_we_o}), 32'({v.sel, v.we}));
        for (int c = 1; c <= v.wt + 1; c++) begin
            if (c > 1) @(negedge clk);
            chk({tag, " stb"}, 32'({s_cyc_o, s_stb_o}), 32'({oh, oh}));
            chk({tag, " early rsp"}, 32'({m_err_o, m_rty_o, m_ack_o}), 32'h0);
            s_ack_i = noise ? (NS'($urandom) & ~oh) : '0;
            s_err_i = noise ? (NS'($urandom) & ~oh) : '0;
            s_rty_i = noise ? (NS'($urandom) & ~oh) : '0;
            if (c == v.wt + 1) begin
                if (v.flags[0]) s_ack_i = s_ack_i | oh;
                if (v.flags[1]) s_rty_i = s_rty_i | oh;
                if (v.flags[2]) s_err_i = s_err_i | oh;
            end
        end
        @(negedge clk);
        s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
        chk({tag, " rsp"}, 32'({m_err_o, m_rty_o, m_ack_o}), 32'(v.exp_rsp));
        chk({tag, " m_dat"}, m_dat_o, v.exp_dat);
        chk({tag, " stb released"}, 32'(s_stb_o), 32'h0);
        idle_inputs();
        @(negedge clk);
        chk({tag, " rsp one cycle"}, 32'({m_err_o, m_rty_o, m_ack_o}), 32'h0);
    endtask

    vec_t table_v [8];
    vec_t rv;
    int   acks;

    initial begin
        reset_n = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = 1'b0;
        s_dat_i = '0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("reset m_outs", 32'({m_ack_o, m_err_o, m_rty_o}), 32'h0);
        chk("reset m_dat", m_dat_o, 32'h0);
        chk("reset s_ctl", 32'({s_cyc_o, s_stb_o, s_sel_o, s_we_o}), 32'h0);
        chk("reset s_adr", s_adr_o, 32'h0);
        chk("reset s_dat", s_dat_o, 32'h0);
        reset_n = 1'b1;

        table_v[0] = mk(32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 4'hF, 1'b0, 0, 3'b001, 0,  3'b001, 32'hDEAD_BEEF);
        table_v[1] = mk(32'h2000_0004, 32'h0000_00A5, 32'h5555_5555, 4'h1, 1'b1, 2, 3'b001, 1,  3'b001, 32'h0);
        table_v[2] = mk(32'h0000_2000, 32'h0,         32'h1234_5678, 4'hF, 1'b0, 1, 3'b001, 2,  3'b001, 32'h3016_745A);
        table_v[3] = mk(32'h0000_0000, 32'h0,         32'hCAFE_F00D, 4'hF, 1'b0, 0, 3'b001, 0,  3'b001, 32'hCAFE_F00D);
        table_v[4] = mk(32'h3000_0000, 32'h0,         32'h0,         4'hF, 1'b0, 0, 3'b000, -1, 3'b100, 32'h0);
        table_v[5] = mk(32'h2000_0010, 32'h0,         32'hAAAA_0000, 4'hF, 1'b0, 0, 3'b111, 1,  3'b100, 32'h0);
        table_v[6] = mk(32'h0000_0020, 32'h0,         32'hBBBB_0000, 4'hF, 1'b0, 1, 3'b011, 0,  3'b010, 32'h0);
        table_v[7] = mk(32'h2000_0000, 32'h0,         32'h0F0F_0F0F, 4'hF, 1'b0, 3, 3'b001, 1,  3'b001, 32'h1E1E_1E1E);
        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), table_v[i], 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] adr;
            logic [2:0]  fl;
            case ($urandom_range(0, 3))
                0: adr = {20'h0, 12'($urandom)};
                1: adr = {24'h20_0000, 8'($urandom)};
                2: adr = {4'h0, 28'($urandom)};
                default: adr = $urandom;
            endcase
            fl = 3'($urandom_range(1, 7));
            rv = model_vec(adr, $urandom, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 3), fl);
            run_vec($sformatf("rnd%0d", n), rv, 1'b1);
        end

        // Back-to-back: stb held high, zero-wait slave 0 -> one ack per 3 cycles.
        @(negedge clk);
        m_adr_i = 32'h0000_0040; m_we_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        acks = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            acks += int'(m_ack_o);
            s_ack_i = {2'b00, s_stb_o[0]};
        end
        idle_inputs();
        chk("b2b ack count", 32'(acks), 32'd3);
        @(negedge clk);
        @(negedge clk);

        // Master abort during BUSY.
        m_adr_i = 32'h0000_0010; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        @(negedge clk);
        chk("abort stb before", 32'(s_stb_o), 32'h1);
        idle_inputs();
        @(negedge clk);
        chk("abort stb after", 32'({s_cyc_o, s_stb_o}), 32'h0);
        chk("abort no rsp", 32'({m_err_o, m_rty_o, m_ack_o}), 32'h0);
        @(negedge clk);
        chk("abort no late rsp", 32'({m_err_o, m_rty_o, m_ack_o}), 32'h0);

        // Silent slave 1.
        m_adr_i = 32'h2000_0008; m_we_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
`ifdef WB_DEC_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("timeout stb held", 32'(s_stb_o), 32'h2);
            chk("timeout no early rsp", 32'({m_err_o, m_rty_o, m_ack_o}), 32'h0);
        end
        @(negedge clk);
        chk("timeout err", 32'({m_err_o, m_rty_o, m_ack_o}), 32'h4);
        chk("timeout stb drop", 32'(s_stb_o), 32'h0);
        idle_inputs();
        run_vec("after timeout", model_vec(32'h2000_000C, 32'h0, 32'h7777_0001, 4'hF, 1'b0, 0, 3'b001), 1'b0);
`else
        for (int c = 1; c <= 20; c++) @(negedge clk);
        chk("no timeout stb held", 32'(s_stb_o), 32'h2);
        chk("no timeout no rsp", 32'({m_err_o, m_rty_o, m_ack_o}), 32'h0);
        idle_inputs();
        @(negedge clk);
        chk("no timeout abort", 32'(s_stb_o), 32'h0);
`endif

        // Async reset mid-BUSY clears everything without waiting for a clock.
        @(negedge clk);
        m_adr_i = 32'h2000_0004; m_dat_i = 32'h1234_0000; m_we_i = 1'b1; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        @(negedge clk);
        chk("rst stb before", 32'(s_stb_o), 32'h2);
        #2 reset_n = 1'b0;
        #1;
        chk("rst mid s_ctl", 32'({s_cyc_o, s_stb_o, s_sel_o, s_we_o}), 32'h0);
        chk("rst mid s_adr", s_adr_o, 32'h0);
        chk("rst mid m_outs", 32'({m_ack_o, m_err_o, m_rty_o}), 32'h0);
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst no rsp", 32'({m_err_o, m_rty_o, m_ack_o, s_stb_o}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
